// File: rtl/fsm_seq_if.sv
// fsm_seq_if
//   Bundles the sequencer's control input and pattern output so the
//   consumer and the sequencer connect through a single port.
//   Signals:
//     enable : advance enable, driven by the master (consumer/controller)
//     out    : 4-bit registered sequence value, driven by the slave (fsm_seq)
//   Modports:
//     master : drives enable, observes out
//     slave  : observes enable, drives out
interface fsm_seq_if;
    logic       enable;
    logic [3:0] out;

    modport master (
        output enable,
        input  out
    );

    modport slave (
        input  enable,
        output out
    );
endinterface

// File: rtl/fsm_seq.sv
// fsm_seq
//   Enable-gated 4-bit triangle-wave sequencer. While enable is high the
//   output ramps 1..15, dwells two cycles at 15, ramps 14..0, then repeats
//   (31-clock period). While enable is low every register holds.
//   Ports:
//     clk   : system clock, all state changes on the rising edge
//     rstb  : synchronous active-low reset
//     bus   : fsm_seq_if.slave -- enable (in), out (4-bit registered out)
module fsm_seq (
    input  logic         clk,
    input  logic         rstb,
    fsm_seq_if.slave     bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] UP   = 2'd1;
    localparam logic [1:0] PEAK = 2'd2;
    localparam logic [1:0] DOWN = 2'd3;

    localparam logic [3:0] OUT_ZERO    = 4'd0;
    localparam logic [3:0] OUT_ONE     = 4'd1;
    localparam logic [3:0] OUT_TOP_M1  = 4'd14;
    localparam logic [3:0] OUT_TOP     = 4'd15;

    logic [1:0] state_q, state_d;
    logic [3:0] out_q,   out_d;
    logic       hold_cnt_q, hold_cnt_d;

    // Next-state logic. Defaults hold every register, so enable low (and any
    // branch that does not touch a register) simply freezes it.
    always_comb begin
        state_d    = state_q;
        out_d      = out_q;
        hold_cnt_d = hold_cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    out_d   = OUT_ONE;
                    state_d = UP;
                end
            end

            UP: begin
                if (bus.enable) begin
                    out_d = out_q + 4'd1;
                    // Leaving 14 lands on 15, which is the first dwell cycle.
                    if (out_q == OUT_TOP_M1) begin
                        state_d    = PEAK;
                        hold_cnt_d = 1'b0;
                    end
                end
            end

            PEAK: begin
                if (bus.enable) begin
                    // hold_cnt counts the extra dwell cycle at 15; it survives
                    // a pause because enable low leaves it untouched.
                    if (!hold_cnt_q) begin
                        hold_cnt_d = 1'b1;
                        out_d      = OUT_TOP;
                    end else begin
                        hold_cnt_d = 1'b0;
                        out_d      = OUT_TOP_M1;
                        state_d    = DOWN;
                    end
                end
            end

            DOWN: begin
                if (bus.enable) begin
                    out_d = out_q - 4'd1;
                    if (out_q == OUT_ONE) begin
                        state_d = IDLE;
                    end
                end
            end

            // Recovery path: any unexpected encoding returns to a clean IDLE
            // whether or not enable is asserted.
            default: begin
                state_d    = IDLE;
                out_d      = OUT_ZERO;
                hold_cnt_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q    <= IDLE;
            out_q      <= OUT_ZERO;
            hold_cnt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Output is taken straight from the register: no combinational path
    // from enable or rstb.
    assign bus.out = out_q;

endmodule

// File: tb/tb_fsm_seq.sv
module tb_fsm_seq;

    logic clk;
    logic rstb;

    fsm_seq_if bus_if ();

    fsm_seq dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    // Reference model: position within the 31-step period. Position 0 is the
    // idle value; 1..15 ramp; 16 is the second cycle at 15; 17..30 descend.
    int          phase;
    logic [3:0]  exp_q[$];
    int          cnt15;
    int          cnt0;

    function automatic logic [3:0] model_out(input int p);
        if (p == 0)       return 4'd0;
        else if (p <= 15) return 4'(p);
        else if (p == 16) return 4'd15;
        else              return 4'(31 - p);
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // One clock edge: drive inputs on the falling edge, advance the model at
    // the rising edge, push the expectation, then pop and compare #1 later.
    task automatic step(input logic en, input logic rb, input string tag);
        logic [3:0] e;
        @(negedge clk);
        bus_if.enable = en;
        rstb          = rb;
        @(posedge clk);
        if (!rb)     phase = 0;
        else if (en) phase = (phase + 1) % 31;
        exp_q.push_back(model_out(phase));
        #1;
        e = exp_q.pop_front();
        $display("step %-10s rstb=%0b en=%0b out=%0d exp=%0d", tag, rb, en, bus_if.out, e);
        check(tag, bus_if.out, e);
        if (bus_if.out === 4'd15) cnt15++;
        if (bus_if.out === 4'd0)  cnt0++;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        phase  = 0;
        cnt15  = 0;
        cnt0   = 0;
        rstb          = 1'b0;
        bus_if.enable = 1'b0;

        // Power-up reset then idle with enable low.
        repeat (2)  step(1'b0, 1'b0, "por_rst");
        repeat (10) step(1'b0, 1'b1, "por_idle");

        // Ramp 1..10.
        repeat (10) step(1'b1, 1'b1, "ramp");

        // Full period after a fresh reset: 1..15,15,14..0,1.
        step(1'b0, 1'b0, "fp_rst");
        cnt15 = 0;
        cnt0  = 0;
        repeat (31) step(1'b1, 1'b1, "full");
        checks++;
        assert (cnt15 == 2) else begin
            errors++;
            $error("FAIL count15 observed=%0d expected=2", cnt15);
        end
        checks++;
        assert (cnt0 == 1) else begin
            errors++;
            $error("FAIL count0 observed=%0d expected=1", cnt0);
        end
        step(1'b1, 1'b1, "full_wrap");

        // Pause mid-ramp at 7.
        step(1'b0, 1'b0, "pz_rst");
        repeat (7)  step(1'b1, 1'b1, "pz_up");
        repeat (5)  step(1'b0, 1'b1, "pz_hold");
        step(1'b1, 1'b1, "pz_resume");
        repeat (7)  step(1'b1, 1'b1, "pz_up2");
        // Now at first cycle of 15: pause during the dwell.
        repeat (3)  step(1'b0, 1'b1, "pk_hold");
        step(1'b1, 1'b1, "pk_dwell2");
        step(1'b1, 1'b1, "pk_exit");
        // Pause again on the second dwell cycle.
        step(1'b0, 1'b0, "pk2_rst");
        repeat (16) step(1'b1, 1'b1, "pk2_up");
        repeat (4)  step(1'b0, 1'b1, "pk2_hold");
        step(1'b1, 1'b1, "pk2_exit");

        // Reset mid-DOWN at out=9 (position 22).
        step(1'b0, 1'b0, "md_rst0");
        repeat (22) step(1'b1, 1'b1, "md_run");
        step(1'b1, 1'b0, "md_rst");
        step(1'b1, 1'b1, "md_restart");
        step(1'b1, 1'b1, "md_up");

        // Reset priority over enable.
        repeat (5) step(1'b1, 1'b0, "rst_prio");
        step(1'b1, 1'b1, "rst_release");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
